color_prom_dl_arbiter: RTL and testbench

- Sequences and shares the write port of the three 1Kx4 colour PROMs (R, G, B) of the final video stage between two requesters: the HPS ioctl ROM download and a debug/OSD palette-patch interface.
- Decodes the download window, tracks per-bank fill counts and raises a palette-ready flag.
- Holds the final RGB output blanked through disp_gate until every bank is fully loaded.

---
 rtl/final_video_pkg.sv | 32 +++
 rtl/prom_bank_counter.sv | 29 ++
 rtl/color_prom_dl_arbiter.sv | 135 +++++++++++++
 tb/tb_color_prom_dl_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/final_video_pkg.sv
// Shared types and constants for the final video stage colour PROM loader.
package final_video_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        READY,
        DBG_WR
    } state_t;

    localparam logic [1:0]  BANK_R       = 2'd0;
    localparam logic [1:0]  BANK_G       = 2'd1;
    localparam logic [1:0]  BANK_B       = 2'd2;
    localparam logic [1:0]  BANK_INVALID = 2'd3;

    localparam logic [24:0] COLOR_PROM_BASE = 25'hD0000;
    localparam int          COUNT_W         = 11;

    // Bank index to {B,G,R} write-enable; the invalid index selects nothing.
    function automatic logic [2:0] bank_onehot(input logic [1:0] bank);
        logic [2:0] we;
        case (bank)
            BANK_R:  we = 3'b001;
            BANK_G:  we = 3'b010;
            BANK_B:  we = 3'b100;
            default: we = 3'b000;
        endcase
        return we;
    endfunction

endpackage

// File: rtl/prom_bank_counter.sv
// Saturating fill counter for one colour PROM bank, with synchronous clear.
module prom_bank_counter
    import final_video_pkg::*;
#(
    parameter int MAX_COUNT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic full
);

    logic [COUNT_W-1:0] count;

    assign full = (count == COUNT_W'(MAX_COUNT));

    // Writes beyond a full bank still land in the PROM, so the count just sticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !full) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/color_prom_dl_arbiter.sv
// Shares the R/G/B colour PROM write port between the HPS ROM download and a
// debug palette-patch port, and gates the display until every bank is loaded.
module color_prom_dl_arbiter
    import final_video_pkg::*;
#(
    parameter logic [24:0] BASE_ADDR = COLOR_PROM_BASE,
    parameter int          BANK_SIZE = 1024,
    parameter int          NUM_BANKS = 3
) (
    input  logic        clk,
    input  logic        VIDEO_RSTn,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    input  logic        ioctl_download,
    input  logic        dbg_req,
    input  logic [1:0]  dbg_bank,
    input  logic [9:0]  dbg_addr,
    input  logic [3:0]  dbg_data,
    output logic        dbg_ack,
    output logic        dbg_err,
    output logic [9:0]  prom_addr,
    output logic [3:0]  prom_data,
    output logic [2:0]  prom_we,
    output logic        pal_ready,
    output logic        disp_gate,
    output logic        busy
);

    localparam logic [24:0] WINDOW_SIZE = 25'(NUM_BANKS * BANK_SIZE);

    state_t              state;
    state_t              next_state;
    logic                dl_q1;
    logic                dl_q2;
    logic                dl_rise;
    logic                dl_fall;
    logic [24:0]         win_off;
    logic                win_valid;
    logic [1:0]          win_bank;
    logic                dl_write;
    logic                dbg_accept;
    logic                enter_load;
    logic                all_full;
    logic [NUM_BANKS-1:0] bank_inc;
    logic [NUM_BANKS-1:0] bank_full;
    logic                unused_data_hi;

    assign unused_data_hi = ^ioctl_data[7:4];

    assign dl_rise = dl_q1 & ~dl_q2;
    assign dl_fall = ~dl_q1 & dl_q2;

    // Addresses below the base wrap to large offsets and fail the range test.
    assign win_off   = ioctl_addr - BASE_ADDR;
    assign win_valid = (win_off < WINDOW_SIZE);
    assign win_bank  = win_off[11:10];
    assign dl_write  = (state == LOAD) && ioctl_download && ioctl_wr && win_valid;

    assign all_full   = &bank_full;
    assign dbg_accept = (state == READY) && (next_state == DBG_WR);
    assign enter_load = (next_state == LOAD) && (state != LOAD);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bank_inc[b] = dl_write && (win_bank == 2'(b));

        prom_bank_counter #(
            .MAX_COUNT(BANK_SIZE)
        ) u_counter (
            .clk   (clk),
            .rst_n (VIDEO_RSTn),
            .clr   (enter_load),
            .inc   (bank_inc[b]),
            .full  (bank_full[b])
        );
    end

    // A new download outranks a pending debug request in READY.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (dl_rise) next_state = LOAD;
            LOAD:    if (dl_fall) next_state = CHECK;
            CHECK:   next_state = all_full ? READY : IDLE;
            READY: begin
                if (dl_rise)      next_state = LOAD;
                else if (dbg_req) next_state = DBG_WR;
            end
            DBG_WR:  next_state = dl_rise ? LOAD : READY;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge VIDEO_RSTn) begin
        if (!VIDEO_RSTn) begin
            state     <= IDLE;
            dl_q1     <= 1'b0;
            dl_q2     <= 1'b0;
            prom_addr <= '0;
            prom_data <= '0;
            prom_we   <= '0;
            dbg_ack   <= 1'b0;
            dbg_err   <= 1'b0;
            pal_ready <= 1'b0;
            disp_gate <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            dl_q1     <= ioctl_download;
            dl_q2     <= dl_q1;
            prom_we   <= '0;
            dbg_ack   <= 1'b0;
            dbg_err   <= 1'b0;
            pal_ready <= (next_state == READY) || (next_state == DBG_WR);
            busy      <= (next_state == LOAD) || (next_state == DBG_WR);
            disp_gate <= pal_ready && !enter_load;

            if (dl_write) begin
                prom_we   <= bank_onehot(win_bank);
                prom_addr <= win_off[9:0];
                prom_data <= ioctl_data[3:0];
            end else if (dbg_accept) begin
                dbg_ack <= 1'b1;
                if (dbg_bank == BANK_INVALID) begin
                    dbg_err <= 1'b1;
                end else begin
                    prom_we   <= bank_onehot(dbg_bank);
                    prom_addr <= dbg_addr;
                    prom_data <= dbg_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_color_prom_dl_arbiter.sv
// Directed bench for the colour PROM download/debug arbiter.
module tb_color_prom_dl_arbiter;

    localparam logic [24:0] BASE = 25'hD0000;

    logic        clk;
    logic        VIDEO_RSTn;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        ioctl_download;
    logic        dbg_req;
    logic [1:0]  dbg_bank;
    logic [9:0]  dbg_addr;
    logic [3:0]  dbg_data;
    logic        dbg_ack;
    logic        dbg_err;
    logic [9:0]  prom_addr;
    logic [3:0]  prom_data;
    logic [2:0]  prom_we;
    logic        pal_ready;
    logic        disp_gate;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    color_prom_dl_arbiter dut (
        .clk            (clk),
        .VIDEO_RSTn     (VIDEO_RSTn),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wr       (ioctl_wr),
        .ioctl_download (ioctl_download),
        .dbg_req        (dbg_req),
        .dbg_bank       (dbg_bank),
        .dbg_addr       (dbg_addr),
        .dbg_data       (dbg_data),
        .dbg_ack        (dbg_ack),
        .dbg_err        (dbg_err),
        .prom_addr      (prom_addr),
        .prom_data      (prom_data),
        .prom_we        (prom_we),
        .pal_ready      (pal_ready),
        .disp_gate      (disp_gate),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] expWe(input int off);
        case (off / 1024)
            0:       return 3'b001;
            1:       return 3'b010;
            2:       return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkZero(input string tag);
        checkOutput(tag, 32'({prom_addr, prom_data, prom_we, dbg_ack, dbg_err, pal_ready, disp_gate, busy}), 32'd0);
    endtask

    // One write strobe; outputs are sampled on the following falling edge.
    task automatic applyStimulus(input logic [24:0] addr, input logic [7:0] data);
        ioctl_addr = addr;
        ioctl_data = data;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
    endtask

    task automatic loadRange(input int startOff, input int count, input bit checkEach);
        int         off;
        logic [7:0] d;
        for (int i = 0; i < count; i++) begin
            off = startOff + i;
            d   = 8'hA0 | 8'(off % 16);
            applyStimulus(BASE + 25'(off), d);
            if (checkEach) begin
                checkOutput("load_we", 32'(prom_we), 32'(expWe(off)));
                if (off % 256 == 7) begin
                    checkOutput("load_addr", 32'(prom_addr), 32'(off % 1024));
                    checkOutput("load_data", 32'(prom_data), 32'(off % 16));
                end
            end
        end
    endtask

    task automatic startDownload();
        ioctl_download = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("start_busy", 32'(busy), 32'd1);
        checkOutput("start_pal", 32'(pal_ready), 32'd0);
        checkOutput("start_gate", 32'(disp_gate), 32'd0);
    endtask

    task automatic endDownload(input bit expectReady);
        ioctl_download = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("end_pal_early", 32'(pal_ready), 32'd0);
        @(negedge clk);
        checkOutput("end_pal", 32'(pal_ready), 32'(expectReady));
        checkOutput("end_gate_early", 32'(disp_gate), 32'd0);
        @(negedge clk);
        checkOutput("end_gate", 32'(disp_gate), 32'(expectReady));
    endtask

    task automatic debugWrite(input logic [1:0] bank, input logic [9:0] addr, input logic [3:0] data,
                              input logic [2:0] weExp, input logic [9:0] addrExp, input logic [3:0] dataExp,
                              input bit errExp);
        dbg_bank = bank;
        dbg_addr = addr;
        dbg_data = data;
        dbg_req  = 1'b1;
        @(negedge clk);
        checkOutput("dbg_ack", 32'(dbg_ack), 32'd1);
        checkOutput("dbg_err", 32'(dbg_err), 32'(errExp));
        checkOutput("dbg_we", 32'(prom_we), 32'(weExp));
        checkOutput("dbg_addr", 32'(prom_addr), 32'(addrExp));
        checkOutput("dbg_data", 32'(prom_data), 32'(dataExp));
        dbg_req = 1'b0;
        @(negedge clk);
        checkOutput("dbg_ack_drop", 32'(dbg_ack), 32'd0);
        checkOutput("dbg_we_drop", 32'(prom_we), 32'd0);
        checkOutput("dbg_pal_hold", 32'(pal_ready), 32'd1);
    endtask

    initial begin
        VIDEO_RSTn     = 1'b0;
        ioctl_addr     = '0;
        ioctl_data     = '0;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        dbg_req        = 1'b0;
        dbg_bank       = '0;
        dbg_addr       = '0;
        dbg_data       = '0;

        repeat (3) @(negedge clk);
        checkZero("reset_state");
        VIDEO_RSTn = 1'b1;
        @(negedge clk);
        checkZero("post_reset");

        // Strobe without a download is ignored.
        applyStimulus(BASE, 8'h07);
        checkOutput("nodl_we_idle", 32'(prom_we), 32'd0);

        // Full download with a debug request held blocked throughout.
        startDownload();
        dbg_bank = 2'd0;
        dbg_addr = 10'h155;
        dbg_data = 4'h3;
        dbg_req  = 1'b1;
        loadRange(0, 3072, 1'b1);
        checkOutput("dbg_blocked", 32'(dbg_ack), 32'd0);
        applyStimulus(BASE + 25'hC00, 8'h55);
        checkOutput("oow_hi_we", 32'(prom_we), 32'd0);
        checkOutput("oow_hi_addr", 32'(prom_addr), 32'h3FF);
        applyStimulus(25'h0CFFFF, 8'h55);
        checkOutput("oow_lo_we", 32'(prom_we), 32'd0);
        checkOutput("oow_lo_data", 32'(prom_data), 32'hF);
        endDownload(1'b1);
        checkOutput("dbg_late_ack", 32'(dbg_ack), 32'd1);
        checkOutput("dbg_late_we", 32'(prom_we), 32'b001);
        checkOutput("dbg_late_addr", 32'(prom_addr), 32'h155);
        checkOutput("dbg_late_data", 32'(prom_data), 32'h3);
        dbg_req = 1'b0;
        @(negedge clk);
        checkOutput("dbg_late_drop", 32'(dbg_ack), 32'd0);
        checkOutput("ready_busy", 32'(busy), 32'd0);

        // Debug writes in READY, including the invalid bank.
        debugWrite(2'd1, 10'h2A5, 4'hC, 3'b010, 10'h2A5, 4'hC, 1'b0);
        debugWrite(2'd3, 10'h111, 4'h1, 3'b000, 10'h2A5, 4'hC, 1'b1);

        // A request held high is re-serviced after one READY cycle.
        dbg_bank = 2'd2;
        dbg_addr = 10'h3FF;
        dbg_data = 4'h5;
        dbg_req  = 1'b1;
        @(negedge clk);
        checkOutput("space_ack1", 32'(dbg_ack), 32'd1);
        checkOutput("space_we1", 32'(prom_we), 32'b100);
        @(negedge clk);
        checkOutput("space_gap", 32'(dbg_ack), 32'd0);
        @(negedge clk);
        checkOutput("space_ack2", 32'(dbg_ack), 32'd1);
        dbg_req = 1'b0;
        @(negedge clk);

        // Download rises while the debug write is in flight.
        dbg_bank       = 2'd0;
        dbg_addr       = 10'h011;
        dbg_data       = 4'h9;
        dbg_req        = 1'b1;
        ioctl_download = 1'b1;
        @(negedge clk);
        checkOutput("coll_ack", 32'(dbg_ack), 32'd1);
        checkOutput("coll_we", 32'(prom_we), 32'b001);
        checkOutput("coll_busy", 32'(busy), 32'd1);
        dbg_req = 1'b0;
        @(negedge clk);
        checkOutput("coll_pal", 32'(pal_ready), 32'd0);
        checkOutput("coll_gate", 32'(disp_gate), 32'd0);
        checkOutput("coll_busy_load", 32'(busy), 32'd1);
        endDownload(1'b0);
        checkOutput("coll_idle", 32'(busy), 32'd0);

        // Short download: bank B one entry short.
        startDownload();
        loadRange(0, 3071, 1'b0);
        endDownload(1'b0);
        checkOutput("short_busy", 32'(busy), 32'd0);

        // Asynchronous reset partway through a download.
        startDownload();
        loadRange(0, 1500, 1'b0);
        checkOutput("mid_we", 32'(prom_we), 32'b010);
        #2;
        VIDEO_RSTn     = 1'b0;
        ioctl_download = 1'b0;
        #1;
        checkZero("async_reset");
        @(negedge clk);
        VIDEO_RSTn = 1'b1;
        @(negedge clk);
        checkZero("after_async_reset");

        // Fresh download with duplicate writes to bank R.
        startDownload();
        loadRange(0, 1024, 1'b0);
        loadRange(0, 6, 1'b0);
        checkOutput("dup_addr", 32'(prom_addr), 32'h005);
        loadRange(1024, 2048, 1'b0);
        endDownload(1'b1);

        applyStimulus(BASE + 25'd5, 8'h0F);
        checkOutput("nodl_we_ready", 32'(prom_we), 32'd0);
        checkOutput("nodl_pal_ready", 32'(pal_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
